dmem_responder: RTL and testbench

//  Responder end of the core's data-memory interface. It accepts one load/store request at a time
//  (valid/ready), inserts a programmable number of wait states, then returns data/status (valid/ready).

---
 rtl/dmem_responder.sv | 203 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time, WAIT_CYCLES wait states,
// funct3 size decode with sign/zero extension and misalignment/range errors.
module dmem_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_we,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int unsigned CNT_W    = (WAIT_CYCLES == 0) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int unsigned MEM_AW   = (DEPTH_WORDS <= 1) ? 1 : $clog2(DEPTH_WORDS);
    localparam int unsigned WIDX_W   = ADDR_W - 2;
    localparam int unsigned CNT_LOAD = (WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // In IDLE the live inputs are used so a zero-wait accept can respond on the same edge.
    logic              in_idle_c;
    logic [ADDR_W-1:0] cur_addr_c;
    logic              cur_we_c;
    logic [2:0]        cur_size_c;
    logic [31:0]       cur_wdata_c;
    logic [WIDX_W-1:0] cur_widx_c;
    logic [MEM_AW-1:0] mem_idx_c;
    logic [31:0]       rd_word_c, wr_word_c, load_val_c;
    logic [7:0]        rd_byte_c;
    logic [15:0]       rd_half_c;
    logic              size_ok_c, misaligned_c, out_of_range_c, cur_err_c;
    logic              accept_c, enter_resp_c, mem_we_c;

    assign in_idle_c   = (state_q == S_IDLE);
    assign cur_addr_c  = in_idle_c ? req_addr  : addr_q;
    assign cur_we_c    = in_idle_c ? req_we    : we_q;
    assign cur_size_c  = in_idle_c ? req_size  : size_q;
    assign cur_wdata_c = in_idle_c ? req_wdata : wdata_q;
    assign cur_widx_c  = cur_addr_c[ADDR_W-1:2];
    assign mem_idx_c   = MEM_AW'(cur_widx_c);
    assign rd_word_c   = mem[mem_idx_c];

    assign out_of_range_c = 32'(cur_widx_c) >= DEPTH_WORDS;
    assign misaligned_c   = ((cur_size_c[1:0] == 2'b01) && cur_addr_c[0]) ||
                            ((cur_size_c[1:0] == 2'b10) && (cur_addr_c[1:0] != 2'b00));
    assign cur_err_c      = !size_ok_c || misaligned_c || out_of_range_c;

    always_comb begin
        size_ok_c = 1'b0;
        case (cur_size_c)
            3'b000, 3'b001, 3'b010: size_ok_c = 1'b1;
            3'b100, 3'b101:         size_ok_c = !cur_we_c;
            default:                size_ok_c = 1'b0;
        endcase
    end

    // Load extraction and extension.
    always_comb begin
        rd_byte_c  = 8'(rd_word_c >> {cur_addr_c[1:0], 3'b000});
        rd_half_c  = cur_addr_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        load_val_c = rd_word_c;
        case (cur_size_c)
            3'b000:  load_val_c = {{24{rd_byte_c[7]}}, rd_byte_c};
            3'b001:  load_val_c = {{16{rd_half_c[15]}}, rd_half_c};
            3'b100:  load_val_c = {24'h0, rd_byte_c};
            3'b101:  load_val_c = {16'h0, rd_half_c};
            default: load_val_c = rd_word_c;
        endcase
    end

    // Store byte-lane merge into the addressed word.
    always_comb begin
        wr_word_c = rd_word_c;
        case (cur_size_c[1:0])
            2'b00: begin
                case (cur_addr_c[1:0])
                    2'b00:   wr_word_c[7:0]   = cur_wdata_c[7:0];
                    2'b01:   wr_word_c[15:8]  = cur_wdata_c[7:0];
                    2'b10:   wr_word_c[23:16] = cur_wdata_c[7:0];
                    default: wr_word_c[31:24] = cur_wdata_c[7:0];
                endcase
            end
            2'b01: begin
                if (cur_addr_c[1]) wr_word_c[31:16] = cur_wdata_c[15:0];
                else               wr_word_c[15:0]  = cur_wdata_c[15:0];
            end
            default: wr_word_c = cur_wdata_c;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = rsp_valid_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        enter_resp_c = 1'b0;
        mem_we_c     = 1'b0;
        accept_c     = in_idle_c && req_valid && req_ready_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    addr_d  = req_addr;
                    we_d    = req_we;
                    size_d  = req_size;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        enter_resp_c = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(CNT_LOAD);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) enter_resp_c = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rdata_d     = 32'h0;
                    err_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Response is captured and the store committed on the edge entering RESP.
        if (enter_resp_c) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            err_d       = cur_err_c;
            rdata_d     = (cur_err_c || cur_we_c) ? 32'h0 : load_val_c;
            mem_we_c    = cur_we_c && !cur_err_c;
        end

        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            size_q      <= 3'b000;
            wdata_q     <= 32'h0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_idx_c] <= wr_word_c;
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench: index 1 is the 2-wait-state responder, index 0 the zero-wait one.
module tb_dmem_responder;
    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [9:0]  req_addr  [2];
    logic        req_we    [2];
    logic [2:0]  req_size  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    exp_t exp_q[$];
    int   n_chk;
    int   n_err;

    localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                           SZ_BU = 3'b100, SZ_HU = 3'b101;

    dmem_responder #(.ADDR_W(10), .DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .req_we(req_we[0]), .req_size(req_size[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.ADDR_W(8), .DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1][7:0]),
        .req_we(req_we[1]), .req_size(req_size[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on responder d, expect (ed, ee); hold rsp_ready low for 'hold' cycles.
    task automatic send(input int d, input logic we, input logic [2:0] sz, input logic [9:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input logic ee,
                        input int hold, input string tag);
        int   n;
        exp_t e;
        logic [31:0] held;
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_size[d]  = sz;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        rsp_ready[d] = 1'b0;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/ready"}, 32'(req_ready[d]), 32'd1);
        e.err  = ee;
        e.data = ed;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid[d] = 1'b0;
        req_we[d]    = ~we;
        req_addr[d]  = ~a;
        req_wdata[d] = ~wd;
        req_size[d]  = 3'b111;
        n = 1;
        while (rsp_valid[d] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/lat"}, 32'(n), (d == 0) ? 32'd1 : 32'd3);
        e = exp_q.pop_front();
        chk({tag, "/data"}, rsp_rdata[d], e.data);
        chk({tag, "/err"}, 32'(rsp_err[d]), 32'(e.err));
        held = rsp_rdata[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 32'(rsp_valid[d]), 32'd1);
            chk({tag, "/hold_data"}, rsp_rdata[d], held);
            chk({tag, "/hold_rdy"}, 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        rsp_ready[d] = 1'b0;
        chk({tag, "/done"}, 32'(rsp_valid[d]), 32'd0);
    endtask

    initial begin
        exp_t e;
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 10'h0;
            req_size[d]  = SZ_W;
            req_wdata[d] = 32'h0;
            rsp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 32'(req_ready[d]), 32'd0);
            chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_rdata", rsp_rdata[d], 32'h0);
            chk("rst_err", 32'(rsp_err[d]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready1", 32'(req_ready[1]), 32'd1);

        // Two-wait-state responder.
        send(1, 1'b1, SZ_W, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0, 0, "sw10");
        send(1, 1'b0, SZ_W, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0, 0, "lw10");
        send(1, 1'b1, SZ_W, 10'h010, 32'h12BE3456, 32'h0, 1'b0, 0, "sw10b");
        send(1, 1'b1, SZ_B, 10'h013, 32'hFFFFFF81, 32'h0, 1'b0, 0, "sb13");
        send(1, 1'b0, SZ_B, 10'h013, 32'h0, 32'hFFFFFF81, 1'b0, 0, "lb13");
        send(1, 1'b0, SZ_BU, 10'h013, 32'h0, 32'h00000081, 1'b0, 0, "lbu13");
        send(1, 1'b0, SZ_H, 10'h012, 32'h0, 32'hFFFF81BE, 1'b0, 0, "lh12");
        send(1, 1'b0, SZ_HU, 10'h012, 32'h0, 32'h000081BE, 1'b0, 0, "lhu12");
        send(1, 1'b0, SZ_H, 10'h010, 32'h0, 32'h00003456, 1'b0, 0, "lh10");
        send(1, 1'b0, SZ_B, 10'h011, 32'h0, 32'h00000034, 1'b0, 0, "lb11");
        send(1, 1'b0, SZ_W, 10'h011, 32'h0, 32'h0, 1'b1, 0, "lw11_mis");
        send(1, 1'b1, SZ_W, 10'h00C, 32'h11223344, 32'h0, 1'b0, 0, "sw0c");
        send(1, 1'b1, SZ_H, 10'h00F, 32'h0000AAAA, 32'h0, 1'b1, 0, "sh0f_mis");
        send(1, 1'b1, SZ_BU, 10'h00C, 32'h000000AA, 32'h0, 1'b1, 0, "sbu_illegal");
        send(1, 1'b0, 3'b011, 10'h00C, 32'h0, 32'h0, 1'b1, 0, "ld011_illegal");
        send(1, 1'b0, SZ_W, 10'h00C, 32'h0, 32'h11223344, 1'b0, 0, "lw0c_kept");
        send(1, 1'b0, SZ_W, 10'h010, 32'h0, 32'h81BE3456, 1'b0, 5, "lw10_hold");

        // Reset during WAIT drops an uncommitted store.
        send(1, 1'b1, SZ_W, 10'h020, 32'hA5A5A5A5, 32'h0, 1'b0, 0, "sw20_prior");
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_size[1]  = SZ_W;
        req_addr[1]  = 10'h020;
        req_wdata[1] = 32'h12345678;
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("mid_wait_ready", 32'(req_ready[1]), 32'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid[1]), 32'd0);
        chk("mid_rst_ready", 32'(req_ready[1]), 32'd0);
        repeat (3) @(negedge clk);
        chk("mid_rst_valid2", 32'(rsp_valid[1]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_mid_rst_ready", 32'(req_ready[1]), 32'd1);
        send(1, 1'b0, SZ_W, 10'h020, 32'h0, 32'hA5A5A5A5, 1'b0, 0, "lw20_prior");

        // Zero-wait responder: range boundary, then back-to-back loads.
        send(0, 1'b1, SZ_W, 10'h0FC, 32'h0BADF00D, 32'h0, 1'b0, 0, "w0_sw_last");
        send(0, 1'b0, SZ_W, 10'h0FC, 32'h0, 32'h0BADF00D, 1'b0, 0, "w0_lw_last");
        send(0, 1'b0, SZ_W, 10'h100, 32'h0, 32'h0, 1'b1, 0, "w0_lw_oor");
        send(0, 1'b1, SZ_W, 10'h100, 32'h55555555, 32'h0, 1'b1, 0, "w0_sw_oor");

        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_size[0]  = SZ_W;
        req_addr[0]  = 10'h0FC;
        rsp_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("b2b_ready", 32'(req_ready[0]), 32'(i % 2 == 0));
            chk("b2b_valid", 32'(rsp_valid[0]), 32'(i % 2 == 1));
            if (req_ready[0] === 1'b1) begin
                e.err  = 1'b0;
                e.data = 32'h0BADF00D;
                exp_q.push_back(e);
            end
            if (rsp_valid[0] === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("b2b_data", rsp_rdata[0], e.data);
                chk("b2b_err", 32'(rsp_err[0]), 32'(e.err));
            end
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b0;
        chk("b2b_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
